// File: rtl/v68k_bus_pkg.sv
// Shared encodings for the 68000-style bus cycle sequencer.
// The GRANT state only exists when BUS_ARB_EN is defined.
package v68k_bus_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_LONG = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int unsigned DTACK_TIMEOUT_DEFAULT = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RECOVER = 3'd3
`ifdef BUS_ARB_EN
    ,
    ST_GRANT   = 3'd4
`endif
  } state_t;

  // The reserved size code behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == SZ_RSVD) ? SZ_WORD : size;
  endfunction

  // Bus half-word for a write: bytes go on both lanes, longs send the high word first.
  function automatic logic [15:0] wr_half(input logic [1:0] size, input logic [31:0] wdata,
                                          input logic second);
    case (size)
      SZ_BYTE: return {wdata[7:0], wdata[7:0]};
      SZ_LONG: return second ? wdata[15:0] : wdata[31:16];
      default: return wdata[15:0];
    endcase
  endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// DTACK watchdog: holds the number of the current WAIT cycle (1 on the first)
// and flags the WAIT cycle whose number equals LIMIT.
module bus_timeout_ctr
  import v68k_bus_pkg::*;
#(
  parameter int unsigned LIMIT = DTACK_TIMEOUT_DEFAULT
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic count,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      cnt <= 8'd1;
    end else if (count) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = count && (cnt == 8'(LIMIT));

endmodule

// File: rtl/bus_cycle_ctrl.sv
// 68000-style asynchronous bus cycle sequencer (byte/word/long, DTACK/BERR/timeout).
// Define BUS_ARB_EN to enable BR/BG/BGACK bus arbitration and the GRANT state.
//
// Handshake: req is a level that the core holds, with all req_* fields stable,
// until the single-cycle ack; err and rdata are valid in the ack cycle. A new
// request is not sampled during the ack cycle, which gives the 1-cycle IDLE gap.
module bus_cycle_ctrl
  import v68k_bus_pkg::*;
#(
  parameter int unsigned DTACK_TIMEOUT = DTACK_TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req,
  input  logic        req_rw,
  input  logic [1:0]  req_size,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [22:0] A,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        RW,
  output logic [15:0] D_out,
  output logic        D_oe,
  input  logic [15:0] D_in,
  input  logic        DTACK,
  input  logic        BERR,
  input  logic        HALT,
  output logic        bus_oe,
  input  logic        BR,
  input  logic        BGACK,
  output logic        BG,
  output logic [2:0]  dbg_state
);

  state_t      state;
  logic        r_rw;
  logic [1:0]  r_size;
  logic [23:0] r_addr;
  logic [31:0] r_wdata;
  logic        second_half;
  logic        pend_err;
  logic [31:0] rd_buf;
  logic        tmo;

  logic [1:0]  in_size;
  logic        in_addr_err;
  logic [23:0] next_addr;
  logic        wait_clear;
  logic        wait_count;

  assign in_size     = norm_size(req_size);
  assign in_addr_err = (in_size != SZ_BYTE) && req_addr[0];
  assign next_addr   = r_addr + 24'd2;
  assign wait_clear  = (state == ST_ADDR);
  assign wait_count  = (state == ST_WAIT);
  assign dbg_state   = state;

  bus_timeout_ctr #(.LIMIT(DTACK_TIMEOUT)) u_timeout (
    .CLK     (CLK),
    .RESET   (RESET),
    .clear   (wait_clear),
    .count   (wait_count),
    .expired (tmo)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_IDLE;
      ack         <= 1'b0;
      err         <= 1'b0;
      rdata       <= 32'd0;
      busy        <= 1'b0;
      A           <= 23'd0;
      AS          <= 1'b0;
      UDS         <= 1'b0;
      LDS         <= 1'b0;
      RW          <= 1'b1;
      D_out       <= 16'd0;
      D_oe        <= 1'b0;
      r_rw        <= 1'b1;
      r_size      <= SZ_WORD;
      r_addr      <= 24'd0;
      r_wdata     <= 32'd0;
      second_half <= 1'b0;
      pend_err    <= 1'b0;
      rd_buf      <= 32'd0;
`ifdef BUS_ARB_EN
      BG          <= 1'b0;
      bus_oe      <= 1'b1;
`endif
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
`ifdef BUS_ARB_EN
          if (BR) begin
            state  <= ST_GRANT;
            BG     <= 1'b1;
            bus_oe <= 1'b0;
            D_oe   <= 1'b0;
          end else
`endif
          if (req && !HALT && !ack) begin
            busy        <= 1'b1;
            r_rw        <= req_rw;
            r_size      <= in_size;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            second_half <= 1'b0;
            pend_err    <= in_addr_err;
            rd_buf      <= 32'd0;
            if (in_addr_err) begin
              state <= ST_RECOVER;
            end else begin
              state <= ST_ADDR;
              A     <= req_addr[23:1];
              RW    <= req_rw;
              D_out <= wr_half(in_size, req_wdata, 1'b0);
              D_oe  <= !req_rw;
            end
          end
        end

        ST_ADDR: begin
          state <= ST_WAIT;
          AS    <= 1'b1;
          UDS   <= (r_size != SZ_BYTE) || !r_addr[0];
          LDS   <= (r_size != SZ_BYTE) || r_addr[0];
        end

        ST_WAIT: begin
          // BERR and the watchdog take precedence over a simultaneous DTACK.
          if (BERR || tmo || DTACK) begin
            state <= ST_RECOVER;
            AS    <= 1'b0;
            UDS   <= 1'b0;
            LDS   <= 1'b0;
            D_oe  <= 1'b0;
            if (BERR || tmo) begin
              pend_err <= 1'b1;
            end else if (r_size == SZ_BYTE) begin
              rd_buf <= {24'd0, r_addr[0] ? D_in[7:0] : D_in[15:8]};
            end else if (r_size == SZ_LONG && !second_half) begin
              rd_buf[31:16] <= D_in;
            end else begin
              rd_buf[15:0] <= D_in;
            end
          end
        end

        ST_RECOVER: begin
          if (r_size == SZ_LONG && !second_half && !pend_err) begin
            state       <= ST_ADDR;
            second_half <= 1'b1;
            r_addr      <= next_addr;
            A           <= next_addr[23:1];
            D_out       <= wr_half(r_size, r_wdata, 1'b1);
            D_oe        <= !r_rw;
          end else begin
            state <= ST_IDLE;
            ack   <= 1'b1;
            err   <= pend_err;
            rdata <= rd_buf;
          end
        end

`ifdef BUS_ARB_EN
        ST_GRANT: begin
          if (!BR && !BGACK) begin
            state  <= ST_IDLE;
            BG     <= 1'b0;
            bus_oe <= 1'b1;
          end
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef BUS_ARB_EN
  assign BG     = 1'b0;
  assign bus_oe = 1'b1;
  wire unused_arb = BR | BGACK;
`endif

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl: a driver/bus responder task issues cycles and
// pushes expected completions; a negedge monitor pops and checks every ack.
module tb_bus_cycle_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        req = 1'b0;
  logic        req_rw = 1'b1;
  logic [1:0]  req_size = 2'b01;
  logic [23:0] req_addr = 24'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        ack, err, busy;
  logic [31:0] rdata;
  logic [22:0] A;
  logic        AS, UDS, LDS, RW, D_oe, bus_oe, BG;
  logic [15:0] D_out;
  logic [15:0] D_in = 16'd0;
  logic        DTACK = 1'b0;
  logic        BERR = 1'b0;
  logic        HALT = 1'b0;
  logic        BR = 1'b0;
  logic        BGACK = 1'b0;
  logic [2:0]  dbg_state;

  bus_cycle_ctrl dut (
    .CLK(CLK), .RESET(RESET), .req(req), .req_rw(req_rw), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .err(err), .rdata(rdata),
    .busy(busy), .A(A), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW), .D_out(D_out),
    .D_oe(D_oe), .D_in(D_in), .DTACK(DTACK), .BERR(BERR), .HALT(HALT),
    .bus_oe(bus_oe), .BR(BR), .BGACK(BGACK), .BG(BG), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: {err, check_rdata, rdata}
  logic [33:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int ack_cnt = 0;

  // Observations gathered by run_txn
  int          phases, lat;
  logic [22:0] obs_a1, obs_a2;
  logic [15:0] obs_d1, obs_d2;
  logic        obs_uds, obs_lds, obs_rw, obs_oe;
  logic        bg_seen, oe_low_seen, busy_at_ack, busy0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin : monitor
    logic [33:0] e;
    if (ack === 1'b1) begin
      ack_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack: err=%b rdata=%h with nothing expected", err, rdata);
      end else begin
        e = exp_q.pop_front();
        if (err !== e[33] || (e[32] && rdata !== e[31:0])) begin
          n_fail++;
          $display("FAIL completion: got err=%b rdata=%h expected err=%b rdata=%h",
                   err, rdata, e[33], e[31:0]);
        end
      end
    end
  end

  // Issues one request and plays the bus slave: DTACK rises after dly WAIT cycles,
  // BERR joins DTACK on address phase berr_ph. HALT/BR are held for the first edges.
  task automatic run_txn(input string nm, input logic rw, input logic [1:0] size,
                         input logic [23:0] addr, input logic [31:0] wdata, input int dly,
                         input logic [15:0] d1, input logic [15:0] d2, input int berr_ph,
                         input logic dtack_en, input int halt_cyc, input int br_cyc,
                         input logic exp_err, input logic exp_chk, input logic [31:0] exp_rdata,
                         input int exp_lat);
    int i;
    int wc;
    logic as_prev;
    exp_q.push_back({exp_err, exp_chk, exp_rdata});
    phases = 0; lat = -1; wc = 0; as_prev = 1'b0;
    bg_seen = 1'b0; oe_low_seen = 1'b0; busy_at_ack = 1'b0; busy0 = 1'b0;
    obs_a1 = '0; obs_a2 = '0; obs_d1 = '0; obs_d2 = '0;
    obs_uds = 1'b0; obs_lds = 1'b0; obs_rw = 1'b0; obs_oe = 1'b0;
    @(negedge CLK);
    req = 1'b1; req_rw = rw; req_size = size; req_addr = addr; req_wdata = wdata;
    HALT = (halt_cyc > 0); BR = (br_cyc > 0); BGACK = 1'b0;
    i = 0;
    while (i < 200 && lat < 0) begin
      @(posedge CLK); #1;
      if (i == 0) busy0 = busy;
      if (halt_cyc > 0 && i == halt_cyc - 1) HALT = 1'b0;
      if (br_cyc > 0 && i == br_cyc - 1) BR = 1'b0;
      bg_seen = bg_seen | BG;
      oe_low_seen = oe_low_seen | !bus_oe;
      if (ack) begin
        lat = i;
        busy_at_ack = busy;
      end else if (AS) begin
        if (!as_prev) begin
          phases++;
          if (phases == 1) begin
            obs_a1 = A; obs_d1 = D_out; obs_uds = UDS; obs_lds = LDS; obs_rw = RW; obs_oe = D_oe;
          end else begin
            obs_a2 = A; obs_d2 = D_out;
          end
        end
        wc++;
        DTACK = dtack_en && (wc > dly);
        BERR = DTACK && (berr_ph == phases);
        D_in = (phases == 1) ? d1 : d2;
      end else begin
        wc = 0; DTACK = 1'b0; BERR = 1'b0;
      end
      as_prev = AS;
      i++;
    end
    check({nm, " latency"}, lat, exp_lat);
    check({nm, " busy_at_ack"}, {31'd0, busy_at_ack}, 32'd1);
    req = 1'b0; DTACK = 1'b0; BERR = 1'b0; HALT = 1'b0; BR = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int acks_before;
    repeat (3) @(posedge CLK);
    #1;
    check("reset ack", {31'd0, ack}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset strobes", {29'd0, AS, UDS, LDS}, 32'd0);
    check("reset RW", {31'd0, RW}, 32'd1);
    check("reset D_oe", {31'd0, D_oe}, 32'd0);
    check("reset A", {9'd0, A}, 32'd0);
    check("reset BG", {31'd0, BG}, 32'd0);
    check("reset bus_oe", {31'd0, bus_oe}, 32'd1);
    check("reset state", {29'd0, dbg_state}, 32'd0);
    RESET = 1'b0;

    // Word read, DTACK immediate
    run_txn("word_rd", 1'b1, 2'b01, 24'h001000, 32'd0, 0, 16'hBEEF, 16'h0, 0, 1'b1, 0, 0,
            1'b0, 1'b1, 32'h0000BEEF, 3);
    check("word_rd A", {9'd0, obs_a1}, 32'h000800);
    check("word_rd UDS/LDS", {30'd0, obs_uds, obs_lds}, 32'd3);
    check("word_rd RW/D_oe", {30'd0, obs_rw, obs_oe}, 32'd2);
    check("word_rd phases", phases, 1);
    check("word_rd busy0", {31'd0, busy0}, 32'd1);

    // Long write across the 24-bit wrap
    run_txn("long_wr", 1'b0, 2'b10, 24'hFFFFFE, 32'hDEADBEEF, 0, 16'h0, 16'h0, 0, 1'b1, 0, 0,
            1'b0, 1'b0, 32'd0, 6);
    check("long_wr A1", {9'd0, obs_a1}, 32'h7FFFFF);
    check("long_wr D1", {16'd0, obs_d1}, 32'h0000DEAD);
    check("long_wr A2", {9'd0, obs_a2}, 32'h000000);
    check("long_wr D2", {16'd0, obs_d2}, 32'h0000BEEF);
    check("long_wr RW/D_oe", {30'd0, obs_rw, obs_oe}, 32'd1);

    // Byte read at odd address, DTACK delayed 2 cycles
    run_txn("byte_rd", 1'b1, 2'b00, 24'h000003, 32'd0, 2, 16'h12AB, 16'h0, 0, 1'b1, 0, 0,
            1'b0, 1'b1, 32'h000000AB, 5);
    check("byte_rd UDS/LDS", {30'd0, obs_uds, obs_lds}, 32'd1);

    // Byte write at odd address: byte replicated on both halves
    run_txn("byte_wr", 1'b0, 2'b00, 24'h000011, 32'hFFFFFF5A, 0, 16'h0, 16'h0, 0, 1'b1, 0, 0,
            1'b0, 1'b0, 32'd0, 3);
    check("byte_wr D_out", {16'd0, obs_d1}, 32'h00005A5A);
    check("byte_wr UDS/LDS", {30'd0, obs_uds, obs_lds}, 32'd1);

    // Address error: no bus cycle
    run_txn("addr_err", 1'b1, 2'b01, 24'h000101, 32'd0, 0, 16'h0, 16'h0, 0, 1'b1, 0, 0,
            1'b1, 1'b0, 32'd0, 1);
    check("addr_err phases", phases, 0);

    // Long read: BERR with DTACK on first half suppresses the second half
    run_txn("long_berr", 1'b1, 2'b10, 24'h002000, 32'd0, 0, 16'h1111, 16'h2222, 1, 1'b1, 0, 0,
            1'b1, 1'b0, 32'd0, 3);
    check("long_berr phases", phases, 1);

    // Long read, both halves
    run_txn("long_rd", 1'b1, 2'b10, 24'h000400, 32'd0, 0, 16'h1234, 16'h5678, 0, 1'b1, 0, 0,
            1'b0, 1'b1, 32'h12345678, 6);
    check("long_rd A2", {9'd0, obs_a2}, 32'h000201);

    // Reserved size behaves as word
    run_txn("rsvd_rd", 1'b1, 2'b11, 24'h000020, 32'd0, 1, 16'hA55A, 16'h0, 0, 1'b1, 0, 0,
            1'b0, 1'b1, 32'h0000A55A, 4);
    check("rsvd_rd UDS/LDS", {30'd0, obs_uds, obs_lds}, 32'd3);

    // DTACK never arrives: 64 WAIT cycles then internal bus error
    run_txn("timeout", 1'b1, 2'b01, 24'h000040, 32'd0, 0, 16'h0, 16'h0, 0, 1'b0, 0, 0,
            1'b1, 1'b0, 32'd0, 66);

    // HALT holds off a new request for two edges
    run_txn("halt_rd", 1'b1, 2'b01, 24'h000030, 32'd0, 0, 16'h0F0F, 16'h0, 0, 1'b1, 2, 0,
            1'b0, 1'b1, 32'h00000F0F, 5);
    check("halt busy0", {31'd0, busy0}, 32'd0);

    // BR together with req in IDLE
`ifdef BUS_ARB_EN
    run_txn("arb_rd", 1'b1, 2'b01, 24'h000050, 32'd0, 0, 16'h7E7E, 16'h0, 0, 1'b1, 0, 2,
            1'b0, 1'b1, 32'h00007E7E, 6);
    check("arb BG seen", {31'd0, bg_seen}, 32'd1);
    check("arb bus_oe low seen", {31'd0, oe_low_seen}, 32'd1);
`else
    run_txn("arb_rd", 1'b1, 2'b01, 24'h000050, 32'd0, 0, 16'h7E7E, 16'h0, 0, 1'b1, 0, 2,
            1'b0, 1'b1, 32'h00007E7E, 3);
    check("arb BG seen", {31'd0, bg_seen}, 32'd0);
    check("arb bus_oe low seen", {31'd0, oe_low_seen}, 32'd0);
`endif

    // Reset in the middle of a WAIT phase: strobes drop, no ack
    acks_before = ack_cnt;
    @(negedge CLK);
    req = 1'b1; req_rw = 1'b1; req_size = 2'b01; req_addr = 24'h000060;
    repeat (3) @(posedge CLK);
    #1;
    check("pre-reset AS", {31'd0, AS}, 32'd1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0; req = 1'b0;
    check("mid-reset strobes", {29'd0, AS, UDS, LDS}, 32'd0);
    check("mid-reset busy", {31'd0, busy}, 32'd0);
    check("mid-reset state", {29'd0, dbg_state}, 32'd0);
    repeat (6) @(posedge CLK);
    #1;
    check("mid-reset no ack", ack_cnt - acks_before, 0);

    check("queue drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
